// File: rtl/hood_pkg.sv
// hood_pkg: shared types and constants for the range-hood mode controller.
//   hood_state_e : operating mode encoding
//   NS_*         : bit positions inside the 16-bit now_state status code
//   FAN_*        : fan level codes
package hood_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_STANDBY,
    ST_LEVEL1,
    ST_LEVEL2,
    ST_LEVEL3,
    ST_CLEAN
  } hood_state_e;

  localparam int NS_PWR   = 15;
  localparam int NS_L1    = 14;
  localparam int NS_CLEAN = 13;
  localparam int NS_L2    = 12;
  localparam int NS_L3    = 11;
  localparam int NS_Q1    = 7;
  localparam int NS_Q2    = 6;
  localparam int NS_Q3    = 5;

  localparam logic [1:0] FAN_OFF = 2'd0;
  localparam logic [1:0] FAN_L1  = 2'd1;
  localparam logic [1:0] FAN_L2  = 2'd2;
  localparam logic [1:0] FAN_L3  = 2'd3;

endpackage

// File: rtl/hood_sec_timer.sv
// hood_sec_timer: 8-bit loadable seconds down-counter.
//   clk, rst   : clock, synchronous active-high reset
//   load       : load load_val into the counter
//   load_val   : value to load
//   tick       : decrement by one (held at zero, never underflows)
//   clr        : force the counter to zero (wins over load)
//   count      : registered count
//   count_nxt  : value count takes at the next edge (lets the owner register decoded status)
//   last       : tick arriving while count==1
module hood_sec_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       tick,
  input  logic       clr,
  output logic [7:0] count,
  output logic [7:0] count_nxt,
  output logic       last
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr)                          count_d = 8'd0;
    else if (load)                    count_d = load_val;
    else if (tick && count_q != 8'd0) count_d = count_q - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= 8'd0;
    else     count_q <= count_d;
  end

  assign count     = count_q;
  assign count_nxt = count_d;
  assign last      = tick && (count_q == 8'd1);

endmodule

// File: rtl/hood_mode_ctrl.sv
// hood_mode_ctrl: range-hood operating-mode controller.
//   clk, rst          : clock, synchronous active-high reset
//   tick_1hz          : one-cycle pulse per second
//   btn_*             : one-cycle debounced button pulses
//   now_state [15:0]  : registered status code for the display path
//   fan_level [1:0]   : 0=off, 1..3=level
//   remain_sec [7:0]  : active countdown, 0 when no timer runs
//   busy              : high in LEVEL3 and CLEAN
// Optional feature macro: HOOD_AUTO_OFF_EN (STANDBY inactivity auto-off).
//
// state      | meaning
// ST_OFF     | hood off, only power is accepted
// ST_STANDBY | powered, fan stopped
// ST_LEVEL1  | extraction level 1
// ST_LEVEL2  | extraction level 2
// ST_LEVEL3  | hurricane level, timed, once per power cycle
// ST_CLEAN   | timed self-clean
module hood_mode_ctrl
  import hood_pkg::*;
#(
  parameter int HURRICANE_SECS = 60,
  parameter int CLEAN_SECS     = 180,
  parameter int IDLE_SECS      = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic        btn_power,
  input  logic        btn_level1,
  input  logic        btn_level2,
  input  logic        btn_level3,
  input  logic        btn_clean,
  output logic [15:0] now_state,
  output logic [1:0]  fan_level,
  output logic [7:0]  remain_sec,
  output logic        busy
);

  localparam logic [7:0] HURR_LD  = 8'(HURRICANE_SECS);
  localparam logic [7:0] CLEAN_LD = 8'(CLEAN_SECS);
  localparam logic [7:0] QTR      = 8'(CLEAN_SECS / 4);

  hood_state_e state_q, state_d;
  logic        l3_used_q, l3_used_d;
  logic [15:0] now_q, now_d;
  logic [1:0]  fan_q, fan_d;
  logic        busy_q, busy_d;

  // Priority resolution: only the highest pending button survives.
  logic sel_pwr, sel_clean, sel_l3, sel_l2, sel_l1, any_btn;
  assign sel_pwr   = btn_power;
  assign sel_clean = !btn_power && btn_clean;
  assign sel_l3    = !btn_power && !btn_clean && btn_level3;
  assign sel_l2    = !btn_power && !btn_clean && !btn_level3 && btn_level2;
  assign sel_l1    = !btn_power && !btn_clean && !btn_level3 && !btn_level2 && btn_level1;
  assign any_btn   = btn_power | btn_clean | btn_level3 | btn_level2 | btn_level1;

  logic       tmr_load, tmr_clr, tmr_tick, tmr_last;
  logic [7:0] tmr_load_val, tmr_cnt, tmr_cnt_nxt;

  // In the timed modes power is the only button ever accepted, so it alone
  // swallows a coincident tick.
  assign tmr_tick = tick_1hz && !btn_power &&
                    (state_q == ST_LEVEL3 || state_q == ST_CLEAN);

  hood_sec_timer u_mode_tmr (
    .clk       (clk),
    .rst       (rst),
    .load      (tmr_load),
    .load_val  (tmr_load_val),
    .tick      (tmr_tick),
    .clr       (tmr_clr),
    .count     (tmr_cnt),
    .count_nxt (tmr_cnt_nxt),
    .last      (tmr_last)
  );

`ifdef HOOD_AUTO_OFF_EN
  logic       idle_load, idle_clr, idle_tick, idle_last;
  logic [7:0] idle_cnt, idle_cnt_nxt;
  logic       unused_idle;

  // Reloaded on STANDBY entry and on any button press; a press also eats the tick.
  assign idle_tick   = tick_1hz && !any_btn && (state_q == ST_STANDBY);
  assign idle_load   = (state_d == ST_STANDBY) && ((state_q != ST_STANDBY) || any_btn);
  assign idle_clr    = (state_d != ST_STANDBY);
  assign unused_idle = ^{idle_cnt, idle_cnt_nxt};

  hood_sec_timer u_idle_tmr (
    .clk       (clk),
    .rst       (rst),
    .load      (idle_load),
    .load_val  (8'(IDLE_SECS)),
    .tick      (idle_tick),
    .clr       (idle_clr),
    .count     (idle_cnt),
    .count_nxt (idle_cnt_nxt),
    .last      (idle_last)
  );
`else
  logic unused_btn;
  assign unused_btn = any_btn;
`endif

  always_comb begin
    state_d      = state_q;
    l3_used_d    = l3_used_q;
    tmr_load     = 1'b0;
    tmr_load_val = 8'd0;
    tmr_clr      = 1'b0;
    unique case (state_q)
      ST_OFF: begin
        if (sel_pwr) state_d = ST_STANDBY;
      end
      ST_STANDBY: begin
        if (sel_pwr) state_d = ST_OFF;
        else if (sel_clean) begin
          state_d      = ST_CLEAN;
          tmr_load     = 1'b1;
          tmr_load_val = CLEAN_LD;
        end
        else if (sel_l3 && !l3_used_q) begin
          state_d      = ST_LEVEL3;
          l3_used_d    = 1'b1;
          tmr_load     = 1'b1;
          tmr_load_val = HURR_LD;
        end
        else if (sel_l2) state_d = ST_LEVEL2;
        else if (sel_l1) state_d = ST_LEVEL1;
`ifdef HOOD_AUTO_OFF_EN
        else if (idle_last) state_d = ST_OFF;
`endif
      end
      ST_LEVEL1, ST_LEVEL2: begin
        if (sel_pwr) state_d = ST_STANDBY;
        else if (sel_l3 && !l3_used_q) begin
          state_d      = ST_LEVEL3;
          l3_used_d    = 1'b1;
          tmr_load     = 1'b1;
          tmr_load_val = HURR_LD;
        end
        else if (sel_l2) state_d = ST_LEVEL2;
        else if (sel_l1) state_d = ST_LEVEL1;
      end
      ST_LEVEL3: begin
        if (sel_pwr) begin
          state_d = ST_STANDBY;
          tmr_clr = 1'b1;
        end
        else if (tmr_last) state_d = ST_LEVEL2;
      end
      ST_CLEAN: begin
        if (sel_pwr) begin
          state_d = ST_STANDBY;
          tmr_clr = 1'b1;
        end
        else if (tmr_last) state_d = ST_STANDBY;
      end
      default: begin
        state_d = ST_OFF;
        tmr_clr = 1'b1;
      end
    endcase
    if (state_d == ST_OFF) l3_used_d = 1'b0;
  end

  // Status decode from next-state values so the outputs leave flops directly.
  logic [7:0] elapsed;
  assign elapsed = CLEAN_LD - tmr_cnt_nxt;

  always_comb begin
    now_d  = 16'h0000;
    fan_d  = FAN_OFF;
    busy_d = 1'b0;
    unique case (state_d)
      ST_OFF: ;
      ST_STANDBY: now_d[NS_PWR] = 1'b1;
      ST_LEVEL1: begin
        now_d[NS_PWR] = 1'b1;
        now_d[NS_L1]  = 1'b1;
        fan_d         = FAN_L1;
      end
      ST_LEVEL2: begin
        now_d[NS_PWR] = 1'b1;
        now_d[NS_L2]  = 1'b1;
        fan_d         = FAN_L2;
      end
      ST_LEVEL3: begin
        now_d[NS_PWR] = 1'b1;
        now_d[NS_L3]  = 1'b1;
        fan_d         = FAN_L3;
        busy_d        = 1'b1;
      end
      ST_CLEAN: begin
        now_d[NS_PWR]   = 1'b1;
        now_d[NS_CLEAN] = 1'b1;
        fan_d           = FAN_L3;
        busy_d          = 1'b1;
        if (elapsed >= 8'(3 * QTR))      now_d[NS_Q3] = 1'b1;
        else if (elapsed >= 8'(2 * QTR)) now_d[NS_Q2] = 1'b1;
        else if (elapsed >= QTR)         now_d[NS_Q1] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_OFF;
      l3_used_q <= 1'b0;
      now_q     <= 16'h0000;
      fan_q     <= FAN_OFF;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      l3_used_q <= l3_used_d;
      now_q     <= now_d;
      fan_q     <= fan_d;
      busy_q    <= busy_d;
    end
  end

  assign now_state  = now_q;
  assign fan_level  = fan_q;
  assign remain_sec = tmr_cnt;
  assign busy       = busy_q;

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// Directed bench for hood_mode_ctrl. dut uses CLEAN_SECS=8 / IDLE_SECS=3,
// dut_dflt uses default parameters for the long-countdown reset case.
module tb_hood_mode_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_1hz = 1'b0;
  logic        btn_power = 1'b0, btn_level1 = 1'b0, btn_level2 = 1'b0;
  logic        btn_level3 = 1'b0, btn_clean = 1'b0;
  logic [15:0] now_state, now2;
  logic [1:0]  fan_level, fan2;
  logic [7:0]  remain_sec, rem2;
  logic        busy, busy2;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  hood_mode_ctrl #(.HURRICANE_SECS(60), .CLEAN_SECS(8), .IDLE_SECS(3)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
    .btn_power(btn_power), .btn_level1(btn_level1), .btn_level2(btn_level2),
    .btn_level3(btn_level3), .btn_clean(btn_clean),
    .now_state(now_state), .fan_level(fan_level), .remain_sec(remain_sec), .busy(busy)
  );

  hood_mode_ctrl dut_dflt (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
    .btn_power(btn_power), .btn_level1(btn_level1), .btn_level2(btn_level2),
    .btn_level3(btn_level3), .btn_clean(btn_clean),
    .now_state(now2), .fan_level(fan2), .remain_sec(rem2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock with the given pulses; outputs sampled 1 ns after the edge.
  task automatic cyc(input logic p, input logic c, input logic l3,
                     input logic l2, input logic l1, input logic t);
    @(negedge clk);
    btn_power = p; btn_clean = c; btn_level3 = l3;
    btn_level2 = l2; btn_level1 = l1; tick_1hz = t;
    @(posedge clk);
    #1;
    btn_power = 0; btn_clean = 0; btn_level3 = 0;
    btn_level2 = 0; btn_level1 = 0; tick_1hz = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0;
  endtask

  logic [15:0] clean_codes [1:8];

  initial begin
    clean_codes[1] = 16'hA000; clean_codes[2] = 16'hA080;
    clean_codes[3] = 16'hA080; clean_codes[4] = 16'hA040;
    clean_codes[5] = 16'hA040; clean_codes[6] = 16'hA020;
    clean_codes[7] = 16'hA020; clean_codes[8] = 16'h8000;

    do_reset();
    chk("rst_ns",   32'(now_state), 32'h0000);
    chk("rst_fan",  32'(fan_level), 0);
    chk("rst_rem",  32'(remain_sec), 0);
    chk("rst_busy", 32'(busy), 0);

    cyc(1,0,0,0,0,0); chk("pwr_ns", 32'(now_state), 32'h8000);
    cyc(0,0,0,0,1,0); chk("l1_ns", 32'(now_state), 32'hC000);
    chk("l1_fan", 32'(fan_level), 1);
    cyc(1,0,0,0,0,0); chk("l1_pwr_ns", 32'(now_state), 32'h8000);

    // hurricane: 55 ticks, then tick+level2 at remain=5, then 4 ticks
    cyc(0,0,1,0,0,0); chk("l3_ns", 32'(now_state), 32'h8800);
    chk("l3_fan", 32'(fan_level), 3);
    chk("l3_busy", 32'(busy), 1);
    chk("l3_rem", 32'(remain_sec), 60);
    for (int i = 0; i < 55; i++) cyc(0,0,0,0,0,1);
    chk("l3_rem5", 32'(remain_sec), 5);
    cyc(0,0,0,1,0,1);
    chk("l3_tl2_ns", 32'(now_state), 32'h8800);
    chk("l3_tl2_rem", 32'(remain_sec), 4);
    for (int i = 0; i < 3; i++) cyc(0,0,0,0,0,1);
    chk("l3_rem1_ns", 32'(now_state), 32'h8800);
    cyc(0,0,0,0,0,1);
    chk("l3_end_ns", 32'(now_state), 32'h9000);
    chk("l3_end_fan", 32'(fan_level), 2);
    chk("l3_end_rem", 32'(remain_sec), 0);
    chk("l3_end_busy", 32'(busy), 0);
    cyc(0,0,0,0,0,1); chk("l2_tick_rem", 32'(remain_sec), 0);

    cyc(0,0,1,0,0,0); chk("l3_used_l2", 32'(now_state), 32'h9000);
    cyc(0,0,0,0,1,0); chk("l2_to_l1", 32'(now_state), 32'hC000);
    cyc(0,1,0,0,0,0); chk("l1_clean_ign", 32'(now_state), 32'hC000);
    cyc(1,0,0,1,0,0); chk("pwr_l2_prio", 32'(now_state), 32'h8000);
    cyc(0,0,1,0,0,0); chk("l3_used_sb", 32'(now_state), 32'h8000);
    cyc(1,0,0,0,0,0); chk("to_off", 32'(now_state), 32'h0000);
    cyc(0,0,0,0,1,0); chk("off_l1_ign", 32'(now_state), 32'h0000);
    cyc(0,1,0,0,0,0); chk("off_cl_ign", 32'(now_state), 32'h0000);
    cyc(1,0,0,0,0,0); chk("off_to_sb", 32'(now_state), 32'h8000);
    cyc(0,0,1,0,0,0); chk("l3_again", 32'(now_state), 32'h8800);
    chk("l3_again_rem", 32'(remain_sec), 60);
    cyc(1,0,0,0,0,0); chk("l3_abort_ns", 32'(now_state), 32'h8000);
    chk("l3_abort_rem", 32'(remain_sec), 0);
    chk("l3_abort_busy", 32'(busy), 0);

    // self-clean, CLEAN_SECS=8
    cyc(0,1,1,0,0,0); chk("cl_ns", 32'(now_state), 32'hA000);
    chk("cl_rem", 32'(remain_sec), 8);
    chk("cl_fan", 32'(fan_level), 3);
    chk("cl_busy", 32'(busy), 1);
    for (int k = 1; k <= 8; k++) begin
      cyc(0,0,0,0,0,1);
      chk($sformatf("cl_tick%0d", k), 32'(now_state), 32'(clean_codes[k]));
      chk($sformatf("cl_rem%0d", k), 32'(remain_sec), 32'(8 - k));
    end
    chk("cl_end_busy", 32'(busy), 0);
    cyc(0,1,0,0,0,0); cyc(0,0,0,1,0,1);
    chk("cl_l2_ign", 32'(now_state), 32'hA000);
    chk("cl_l2_ign_rem", 32'(remain_sec), 7);
    cyc(1,0,0,0,0,1); chk("cl_abort", 32'(now_state), 32'h8000);
    chk("cl_abort_rem", 32'(remain_sec), 0);

    // long countdown on default-parameter instance, then reset mid-clean
    do_reset();
    cyc(1,0,0,0,0,0); cyc(0,1,0,0,0,0);
    chk("d_cl_rem", 32'(rem2), 180);
    for (int i = 0; i < 80; i++) cyc(0,0,0,0,0,1);
    chk("d_cl_rem100", 32'(rem2), 100);
    chk("d_cl_q1", 32'(now2), 32'hA080);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("d_rst_ns", 32'(now2), 0);
    chk("d_rst_fan", 32'(fan2), 0);
    chk("d_rst_rem", 32'(rem2), 0);
    chk("d_rst_busy", 32'(busy2), 0);
    chk("rst_ns2", 32'(now_state), 0);
    @(negedge clk); rst = 1'b0;

`ifdef HOOD_AUTO_OFF_EN
    cyc(1,0,0,0,0,0); cyc(0,0,1,0,0,0); cyc(1,0,0,0,0,0);
    chk("idle_sb", 32'(now_state), 32'h8000);
    cyc(0,0,0,0,0,1); cyc(0,0,0,0,0,1);
    chk("idle_2t", 32'(now_state), 32'h8000);
    cyc(0,0,1,0,0,0);
    cyc(0,0,0,0,0,1); cyc(0,0,0,0,0,1);
    chk("idle_restart", 32'(now_state), 32'h8000);
    cyc(0,0,0,0,0,1);
    chk("idle_off", 32'(now_state), 32'h0000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
